// File: rtl/phys_reg_free_list.sv
// Circular free list of physical register tags: rename pops from head, commit pushes at tail.
// Pops, pushes and flush restores take effect one cycle later; rename stalls while the list is empty.
module phys_reg_free_list #(
    parameter int NUM_PHYS = 64,
    parameter int NUM_ARCH = 32,
    localparam int PHYS_W = $clog2(NUM_PHYS),
    localparam int DEPTH  = NUM_PHYS - NUM_ARCH,
    localparam int PTR_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alloc_req,
    output logic              alloc_ready,
    output logic [PHYS_W-1:0] alloc_phys,
    input  logic              free_valid,
    input  logic [PHYS_W-1:0] free_phys,
    input  logic              commit_alloc,
    input  logic              flush,
    output logic [PTR_W-1:0]  free_count,
    output logic              overflow_err
);

    localparam int IDX_W = PTR_W - 1;

    logic [PHYS_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  cmt_head;
    logic [PTR_W-1:0]  tail;
    logic [PTR_W-1:0]  cmt_n;
    logic              full;
    logic              pop;
    logic              push_try;
    logic              push;

    assign free_count  = tail - head;
    assign alloc_ready = (free_count != '0);
    assign alloc_phys  = mem[head[IDX_W-1:0]];

    assign full     = (tail[PTR_W-1] != head[PTR_W-1]) && (tail[IDX_W-1:0] == head[IDX_W-1:0]);
    assign pop      = alloc_req && alloc_ready && !flush;
    // Tag 0 is the hardwired x0 mapping and never returns to the pool.
    assign push_try = free_valid && (free_phys != '0);
    assign push     = push_try && !full;
    assign cmt_n    = cmt_head + PTR_W'(commit_alloc);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= PHYS_W'(NUM_ARCH + i);
            end
            head         <= '0;
            cmt_head     <= '0;
            tail         <= PTR_W'(DEPTH);
            overflow_err <= 1'b0;
        end else begin
            if (push) begin
                mem[tail[IDX_W-1:0]] <= free_phys;
                tail                 <= tail + PTR_W'(1);
            end
            if (push_try && full) begin
                overflow_err <= 1'b1;
            end
            cmt_head <= cmt_n;
            // The committing instruction is older than the flush, so its tag stays allocated.
            if (flush) begin
                head <= cmt_n;
            end else if (pop) begin
                head <= head + PTR_W'(1);
            end
        end
    end

    a_cmt_behind_head: assert property (@(posedge clk) disable iff (rst)
        commit_alloc |-> (cmt_head != head));

endmodule
